// File: rtl/uart_write_arbiter.sv
// Round-robin write-lock arbiter muxing one thread's byte stream onto the shared UART TX.
// Grant appears one cycle after request; one idle release cycle between grants; only the owner sees uart_ready.
module uart_write_arbiter #(
  parameter int NTHREADS = 2,
  parameter int BITWIDTH = 32,
  localparam int IDXW = (NTHREADS > 1) ? $clog2(NTHREADS) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NTHREADS-1:0]   lock_req,
  output logic [NTHREADS-1:0]   lock_res,
  output logic [NTHREADS-1:0]   thread_ready,
  input  logic [8*NTHREADS-1:0] thread_data,
  input  logic [NTHREADS-1:0]   thread_data_valid,
  output logic [7:0]            uart_data,
  output logic                  uart_data_valid,
  input  logic                  uart_ready,
  output logic [IDXW-1:0]       owner,
  output logic                  busy,
  output logic [BITWIDTH-1:0]   grant_bytes
);

  typedef enum logic [1:0] {ARB_IDLE, ARB_GRANT, ARB_RELEASE} arb_state_t;

  arb_state_t          state_q, state_d;
  logic [NTHREADS-1:0] lock_res_q, lock_res_d;
  logic [IDXW-1:0]     owner_q, owner_d;
  logic [IDXW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [BITWIDTH-1:0] grant_bytes_q, grant_bytes_d;

  logic                sel_found;
  logic [IDXW-1:0]     sel_idx;
  logic [IDXW-1:0]     cand_idx;
  int                  cand;

  // First requester at or after rr_ptr, wrapping modulo NTHREADS.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 0; k < NTHREADS; k++) begin
      cand = int'(rr_ptr_q) + k;
      if (cand >= NTHREADS) cand = cand - NTHREADS;
      cand_idx = IDXW'(cand);
      if (!sel_found && lock_req[cand_idx]) begin
        sel_found = 1'b1;
        sel_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    lock_res_d    = lock_res_q;
    owner_d       = owner_q;
    rr_ptr_d      = rr_ptr_q;
    grant_bytes_d = grant_bytes_q;
    case (state_q)
      ARB_IDLE: begin
        if (sel_found) begin
          owner_d       = sel_idx;
          lock_res_d    = NTHREADS'(1) << sel_idx;
          grant_bytes_d = '0;
          state_d       = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        if (uart_data_valid && uart_ready) grant_bytes_d = grant_bytes_q + BITWIDTH'(1);
        if (!lock_req[owner_q]) begin
          lock_res_d = '0;
          rr_ptr_d   = (owner_q == IDXW'(NTHREADS - 1)) ? '0 : owner_q + IDXW'(1);
          state_d    = ARB_RELEASE;
        end
      end
      ARB_RELEASE: begin
        state_d = ARB_IDLE;
      end
      default: begin
        state_d    = ARB_IDLE;
        lock_res_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ARB_IDLE;
      lock_res_q    <= '0;
      owner_q       <= '0;
      rr_ptr_q      <= '0;
      grant_bytes_q <= '0;
    end else begin
      state_q       <= state_d;
      lock_res_q    <= lock_res_d;
      owner_q       <= owner_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_bytes_q <= grant_bytes_d;
    end
  end

  // Non-owner bytes are dropped, never queued.
  always_comb begin
    uart_data       = '0;
    uart_data_valid = 1'b0;
    thread_ready    = '0;
    if (state_q == ARB_GRANT) begin
      uart_data             = thread_data[8*owner_q +: 8];
      uart_data_valid       = thread_data_valid[owner_q];
      thread_ready[owner_q] = uart_ready;
    end
  end

  assign lock_res    = lock_res_q;
  assign owner       = owner_q;
  assign busy        = (state_q != ARB_IDLE);
  assign grant_bytes = grant_bytes_q;

endmodule

// File: tb/tb_uart_write_arbiter.sv
// Bench for uart_write_arbiter: directed scenarios plus randomized traffic against a grant-level model.
module tb_uart_write_arbiter;
  localparam int N  = 4;
  localparam int BW = 4;

  logic          clock;
  logic          reset;
  logic [N-1:0]  lock_req;
  logic [N-1:0]  lock_res;
  logic [N-1:0]  thread_ready;
  logic [8*N-1:0] thread_data;
  logic [N-1:0]  thread_data_valid;
  logic [7:0]    uart_data;
  logic          uart_data_valid;
  logic          uart_ready;
  logic [1:0]    owner;
  logic          busy;
  logic [BW-1:0] grant_bytes;

  int n_checks = 0;
  int n_errors = 0;

  uart_write_arbiter #(.NTHREADS(N), .BITWIDTH(BW)) dut (
    .clock(clock), .reset(reset), .lock_req(lock_req), .lock_res(lock_res),
    .thread_ready(thread_ready), .thread_data(thread_data),
    .thread_data_valid(thread_data_valid), .uart_data(uart_data),
    .uart_data_valid(uart_data_valid), .uart_ready(uart_ready),
    .owner(owner), .busy(busy), .grant_bytes(grant_bytes)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Grant-level model: who holds the lock, whether the mandatory gap is pending,
  // where the rotation restarts, and how many bytes the current grant moved.
  bit m_live = 0;
  bit m_granted = 0;
  bit m_gap = 0;
  int m_owner = 0;
  int m_ptr = 0;
  int m_bytes = 0;

  always @(posedge clock) begin
    if (reset) begin
      m_live = 1; m_granted = 0; m_gap = 0; m_owner = 0; m_ptr = 0; m_bytes = 0;
    end else if (m_granted) begin
      if (thread_data_valid[m_owner] && uart_ready) m_bytes = (m_bytes + 1) % (1 << BW);
      if (!lock_req[m_owner]) begin
        m_granted = 0;
        m_gap     = 1;
        m_ptr     = (m_owner + 1) % N;
      end
    end else if (m_gap) begin
      m_gap = 0;
    end else if (lock_req != 0) begin
      bit found;
      found = 0;
      for (int k = 0; k < N; k++) begin
        if (!found && lock_req[(m_ptr + k) % N]) begin
          found   = 1;
          m_owner = (m_ptr + k) % N;
        end
      end
      m_granted = 1;
      m_bytes   = 0;
    end
  end

  logic [N-1:0] prev_req = '0;
  logic [N-1:0] prev_lock = '0;
  logic         prev_rst = 1'b1;
  int           waits [N];

  initial for (int i = 0; i < N; i++) waits[i] = 0;

  always @(negedge clock) begin
    if (m_live) begin
      logic [N-1:0] e_lock;
      logic [N-1:0] e_tr;
      int           g;
      e_lock = m_granted ? N'(1 << m_owner) : '0;
      e_tr   = (m_granted && uart_ready) ? N'(1 << m_owner) : '0;
      check("lock_res", lock_res, e_lock);
      check("owner", owner, m_owner);
      check("busy", busy, m_granted || m_gap);
      check("grant_bytes", grant_bytes, m_bytes);
      check("uart_data", uart_data, m_granted ? thread_data[8*m_owner +: 8] : 8'h00);
      check("uart_data_valid", uart_data_valid, m_granted ? thread_data_valid[m_owner] : 1'b0);
      check("thread_ready", thread_ready, e_tr);
      check("lock_onehot", $countones(lock_res) <= 1, 1);

      // A requester held continuously must win before N-1 others are granted ahead of it.
      for (int i = 0; i < N; i++) if (prev_rst || !prev_req[i]) waits[i] = 0;
      if (lock_res != 0 && prev_lock == 0) begin
        g = 0;
        for (int i = 0; i < N; i++) if (lock_res[i]) g = i;
        for (int i = 0; i < N; i++) begin
          if (i == g) waits[i] = 0;
          else if (prev_req[i]) begin
            waits[i]++;
            check("starvation", waits[i] <= N - 1, 1);
          end
        end
      end
      prev_req  = lock_req;
      prev_lock = lock_res;
      prev_rst  = reset;
    end
  end

  initial begin
    reset = 1; lock_req = '0; thread_data = '0; thread_data_valid = '0; uart_ready = 0;
    tick(); tick(); reset = 0;
    @(negedge clock);
    check("rst_lock_res", lock_res, 4'b0000);
    check("rst_owner", owner, 0);
    check("rst_busy", busy, 0);
    check("rst_bytes", grant_bytes, 0);

    tick(); lock_req = 4'b0011;
    tick(); @(negedge clock);
    check("first_grant", lock_res, 4'b0001);
    check("first_owner", owner, 0);
    check("first_busy", busy, 1);

    tick(); thread_data = 32'h0000_0011; thread_data_valid = 4'b0001; uart_ready = 1;
    @(negedge clock);
    check("byte_11", uart_data, 8'h11);
    check("ready_owner", thread_ready, 4'b0001);
    tick(); thread_data = 32'h0000_0022;
    @(negedge clock);
    check("byte_22", uart_data, 8'h22);
    check("ready_thr1", thread_ready[1], 0);
    tick(); thread_data_valid = 4'b0000;
    @(negedge clock);
    check("bytes_two", grant_bytes, 2);

    tick(); uart_ready = 0; thread_data_valid = 4'b0011; thread_data = 32'h0000_AA33;
    @(negedge clock);
    check("stall_ready", thread_ready, 4'b0000);
    check("owner_byte", uart_data, 8'h33);
    tick(); @(negedge clock);
    check("stall_bytes", grant_bytes, 2);
    check("no_foreign", uart_data == 8'hAA, 0);

    tick(); lock_req = 4'b0010; thread_data_valid = 4'b0000;
    tick(); @(negedge clock);
    check("release_lock", lock_res, 4'b0000);
    check("release_busy", busy, 1);
    tick(); @(negedge clock);
    check("idle_lock", lock_res, 4'b0000);
    check("idle_busy", busy, 0);
    tick(); @(negedge clock);
    check("grant_thr1", lock_res, 4'b0010);
    check("owner_thr1", owner, 1);

    tick(); lock_req = 4'b0011;
    tick(); lock_req = 4'b0001;
    tick(); @(negedge clock);
    check("rot_release", lock_res, 4'b0000);
    tick(); tick(); @(negedge clock);
    check("rot_grant0", lock_res, 4'b0001);
    check("rot_owner0", owner, 0);

    tick(); thread_data_valid = 4'b0001; uart_ready = 1;
    tick(); thread_data_valid = 4'b0000; reset = 1;
    @(negedge clock);
    check("pre_rst_bytes", grant_bytes, 1);
    tick(); @(negedge clock);
    check("midrst_lock", lock_res, 4'b0000);
    check("midrst_busy", busy, 0);
    check("midrst_bytes", grant_bytes, 0);
    tick(); reset = 0;
    tick(); @(negedge clock);
    check("regrant", lock_res, 4'b0001);

    for (int c = 0; c < 4000; c++) begin
      tick();
      reset = ($urandom_range(0, 499) == 0);
      for (int i = 0; i < N; i++) begin
        if (!lock_req[i]) begin
          if ($urandom_range(0, 3) == 0) lock_req[i] = 1'b1;
        end else if (lock_res[i]) begin
          if ($urandom_range(0, 7) == 0) lock_req[i] = 1'b0;
        end else if ($urandom_range(0, 63) == 0) begin
          lock_req[i] = 1'b0;
        end
      end
      thread_data       = $urandom;
      thread_data_valid = N'($urandom);
      uart_ready        = ($urandom_range(0, 3) != 0);
    end

    tick(); tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
